// File: rtl/nibble_serial_alu_if.sv
// Byte-wide request/result bundle between a requester and the nibble-serial ALU.
// The requester drives operands and start; the ALU returns ctrl/busy/done/q.
interface nibble_serial_alu_if;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic       ctrl;
    logic       busy;
    logic       done;
    logic [8:0] q;

    modport master (
        output start, a, b, mode,
        input  ctrl, busy, done, q
    );

    modport slave (
        input  start, a, b, mode,
        output ctrl, busy, done, q
    );
endinterface

// File: rtl/nibble_serial_alu.sv
// Sequential 8-bit add/subtract done as two 4-bit steps (low nibble, then high
// nibble with the inter-nibble carry held in a register); reassembles a 9-bit result.
module nibble_serial_alu (
    input logic                clk,
    input logic                rst,
    nibble_serial_alu_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] a_q, b_q;
    logic       mode_q;
    logic [3:0] r_lo_q;
    logic       c_q;
    logic [8:0] q_q;

    logic       load_op;
    logic       load_lo;
    logic       load_q;
    logic [7:0] bop;
    logic [4:0] s_lo;
    logic [4:0] s_hi;

    // Subtract is A + ~B + 1: the +1 enters as the low-nibble carry-in.
    always_comb begin
        bop  = mode_q ? ~b_q : b_q;
        s_lo = {1'b0, a_q[3:0]} + {1'b0, bop[3:0]} + {4'b0000, mode_q};
        s_hi = {1'b0, a_q[7:4]} + {1'b0, bop[7:4]} + {4'b0000, c_q};
    end

    always_comb begin
        state_d = state_q;
        load_op = 1'b0;
        load_lo = 1'b0;
        load_q  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    load_op = 1'b1;
                    state_d = StLow;
                end
            end
            StLow: begin
                load_lo = 1'b1;
                state_d = StHigh;
            end
            StHigh: begin
                load_q  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= 8'h00;
            b_q    <= 8'h00;
            mode_q <= 1'b0;
        end else if (load_op) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            mode_q <= bus.mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo_q <= 4'h0;
            c_q    <= 1'b0;
        end else if (load_lo) begin
            r_lo_q <= s_lo[3:0];
            c_q    <= s_lo[4];
        end
    end

    // q is sticky across IDLE; only the HIGH step or reset changes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 9'h000;
        end else if (load_q) begin
            q_q <= {s_hi[4], s_hi[3:0], r_lo_q};
        end
    end

    assign bus.ctrl = (state_q == StHigh);
    assign bus.busy = (state_q != StIdle);
    assign bus.done = (state_q == StDone);
    assign bus.q    = q_q;

    a_done_one_cycle: assert property (@(posedge clk) disable iff (rst)
        bus.done |=> !bus.done);
    a_ctrl_only_busy: assert property (@(posedge clk) disable iff (rst)
        bus.ctrl |-> bus.busy);
    a_start_to_done: assert property (@(posedge clk) disable iff (rst)
        (state_q == StIdle && bus.start) |=> ##2 bus.done);

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Scoreboard bench for nibble_serial_alu: expected results are queued at stimulus
// time and retired by a monitor on each done pulse.
module tb_nibble_serial_alu;

    logic clk;
    logic rst;

    nibble_serial_alu_if bus ();

    nibble_serial_alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    logic [8:0] exp_q[$];
    int         done_cycles[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Retire one expected result per done pulse.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            done_cnt++;
            done_cycles.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_done: got done with q=%h, required no done", bus.q);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if (bus.q !== e) begin
                    failures++;
                    $display("FAIL sb_q: got %h, required %h", bus.q, e);
                end
            end
        end
    end

    // Drives one op at the current time; returns at the negedge after edge N+3.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                          input logic [8:0] e, input string name);
        bus.a = a; bus.b = b; bus.mode = m; bus.start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = ~a; bus.b = ~b; bus.mode = ~m;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.ctrl, bus.done} !== 3'b100) begin
            failures++;
            $display("FAIL %s_low: busy/ctrl/done=%b, required 100", name,
                     {bus.busy, bus.ctrl, bus.done});
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.ctrl, bus.done} !== 3'b110) begin
            failures++;
            $display("FAIL %s_high: busy/ctrl/done=%b, required 110", name,
                     {bus.busy, bus.ctrl, bus.done});
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.ctrl, bus.done} !== 3'b101) begin
            failures++;
            $display("FAIL %s_done: busy/ctrl/done=%b, required 101", name,
                     {bus.busy, bus.ctrl, bus.done});
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.ctrl, bus.done} !== 3'b000 || bus.q !== e) begin
            failures++;
            $display("FAIL %s_idle: busy/ctrl/done=%b q=%h, required 000 q=%h", name,
                     {bus.busy, bus.ctrl, bus.done}, bus.q, e);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.mode = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.ctrl, bus.done} !== 3'b000 || bus.q !== 9'h000) begin
            failures++;
            $display("FAIL reset_outputs: busy/ctrl/done=%b q=%h, required 000 q=000",
                     {bus.busy, bus.ctrl, bus.done}, bus.q);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_no_start: busy=%b, required 0", bus.busy);
        end
    endtask

    task automatic test_add();
        run_op(8'h24, 8'h81, 1'b0, 9'h0A5, "add_nocarry");
        run_op(8'hF9, 8'hC6, 1'b0, 9'h1BF, "add_carry_out");
        run_op(8'h0D, 8'h8D, 1'b0, 9'h09A, "add_lo_carry");
    endtask

    task automatic test_sub();
        run_op(8'h76, 8'h3D, 1'b1, 9'h139, "sub_noborrow");
        run_op(8'h12, 8'h8F, 1'b1, 9'h083, "sub_borrow");
        run_op(8'h5A, 8'h5A, 1'b1, 9'h100, "sub_equal");
    endtask

    task automatic test_busy_reject();
        int d0;
        d0 = done_cnt;
        @(posedge clk); #1;
        bus.a = 8'h33; bus.b = 8'h11; bus.mode = 1'b0; bus.start = 1'b1;
        exp_q.push_back(9'h044);
        @(posedge clk); #1;                        // edge N accepts
        bus.a = 8'hFF; bus.b = 8'hFF; bus.mode = 1'b1;
        @(posedge clk); #1;                        // N+1 ignored
        bus.a = 8'h80; bus.b = 8'h01; bus.mode = 1'b0;
        @(posedge clk); #1;                        // N+2 ignored
        bus.start = 1'b0;
        @(posedge clk); #1;                        // N+3 back to IDLE
        checks++;
        if (done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL busy_reject_done_count: got %0d, required 1", done_cnt - d0);
        end
        bus.a = 8'h0F; bus.b = 8'h01; bus.mode = 1'b0; bus.start = 1'b1;
        exp_q.push_back(9'h010);
        @(posedge clk); #1;                        // N+4 accepted
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.ctrl} !== 2'b10) begin
            failures++;
            $display("FAIL busy_reject_next_accept: busy/ctrl=%b, required 10",
                     {bus.busy, bus.ctrl});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 2 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_reject_total: dones=%0d busy=%b, required 2 and 0",
                     done_cnt - d0, bus.busy);
        end
    endtask

    task automatic test_reset_midop();
        int d0;
        d0 = done_cnt;
        bus.a = 8'h55; bus.b = 8'h22; bus.mode = 1'b0; bus.start = 1'b1;
        exp_q.push_back(9'h077);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #2;                        // now in HIGH
        checks++;
        if (bus.ctrl !== 1'b1) begin
            failures++;
            $display("FAIL midop_in_high: ctrl=%b, required 1", bus.ctrl);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.ctrl, bus.done} !== 3'b000 || bus.q !== 9'h000) begin
            failures++;
            $display("FAIL midop_async_clear: busy/ctrl/done=%b q=%h, required 000 q=000",
                     {bus.busy, bus.ctrl, bus.done}, bus.q);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt !== d0) begin
            failures++;
            $display("FAIL midop_no_done: got %0d dones, required 0", done_cnt - d0);
        end
        rst = 1'b0;
        run_op(8'hE5, 8'h77, 1'b0, 9'h15C, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [7:0] av[3];
        logic [7:0] bv[3];
        logic [8:0] ev[3];
        int         d0;
        av = '{8'h65, 8'h01, 8'hC5};
        bv = '{8'h12, 8'h0D, 8'hAA};
        ev = '{9'h077, 9'h00E, 9'h16F};
        d0 = done_cnt;
        done_cycles.delete();
        bus.mode = 1'b0; bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.a = av[i]; bus.b = bv[i];
            exp_q.push_back(ev[i]);
            repeat (4) @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 3) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d, required 3", done_cnt - d0);
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (done_cycles[i] - done_cycles[i-1] !== 4) begin
                    failures++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles, required 4", i,
                             done_cycles[i] - done_cycles[i-1]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_busy_reject();
        test_reset_midop();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d results never produced, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1);
    end

endmodule

// File: doc/nibble_serial_alu.md
# nibble_serial_alu

Sequential byte adder/subtractor that performs one 8-bit operation as two nibble-wide steps: low nibble first, then high nibble with the carry held in a register. It is the sequencing end of the team's nibble-add datapath. It drives the nibble-select the way the combinational nibble adder consumes it, and it reassembles the two 5-bit nibble results into one 9-bit byte result. It sits between a byte-wide requester (start/done handshake) and the nibble arithmetic.

## Interface
Parameters: none. Widths are fixed at 8-bit operands and 4-bit nibbles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- A  in  8  operand A; captured on the accepted start
- B  in  8  operand B; captured on the accepted start
- mode  in  1  0 = A+B, 1 = A−B; captured on the accepted start
- ctrl  out  1  nibble select in progress: 0 = low nibble, 1 = high nibble
- busy  out  1  high from the cycle after an accepted start until the return to IDLE
- done  out  1  one-cycle pulse; q is valid and new in that cycle
- q  out  9  result: q[8] = carry-out, q[7:0] = byte result

## Operation
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - start=1 → latch A, B and mode → LOW.
  - start=0 → stay in IDLE.
- LOW:
  - bop = mode ? ~B : B.
  - cin = mode.
  - s_lo[4:0] = A[3:0] + bop[3:0] + cin (5-bit arithmetic, no truncation).
  - Register r_lo = s_lo[3:0] and carry c = s_lo[4] → HIGH.
- HIGH:
  - s_hi[4:0] = A[7:4] + bop[7:4] + c.
  - Load q = {s_hi[4], s_hi[3:0], r_lo} → DONE.
- DONE: done=1 for this cycle only → IDLE.
- ctrl output:
  - 1 in HIGH.
  - 0 in all other states.
- busy output:
  - 1 in LOW, HIGH and DONE.
  - 0 in IDLE.
- Subtract convention: q[8]=1 means no borrow (A ≥ B unsigned). q[8]=0 means borrow, and q[7:0] is the two's-complement wrap.
- start is ignored in LOW, HIGH and DONE. No queuing; the requester retries from IDLE.
- Operands are latched, so A, B and mode may change freely after the accepted start without affecting the result.
- q holds its last value until the next HIGH→DONE load. It is not cleared on return to IDLE.

## Timing
- Reset: rst=1 forces the following immediately, independent of clk:
  - state = IDLE
  - q = 9'h000, r_lo = 0, c = 0
  - done = 0, busy = 0, ctrl = 0
- Reset mid-operation (LOW, HIGH or DONE) aborts the operation: no done pulse and q = 0. A start on the first edge after rst falls is accepted normally.
- Latency, with start sampled high at edge N in IDLE:
  - cycle after N: LOW
  - cycle after N+1: HIGH, ctrl=1
  - cycle after N+2: DONE, done=1, q valid
  - cycle after N+3: IDLE
  - Start-to-done is 3 edges.
- Throughput: one operation per 4 cycles. The earliest next start is accepted at edge N+4.
- A start held high continuously issues a new operation every 4 cycles, using the A/B/mode values present at each accepting edge.
- Outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.

## Test plan
- Add, no carry: A=8'h24, B=8'h81, mode=0, start pulse → ctrl=0,1 on successive busy cycles; done after 3 edges with q=9'h0A5.
- Add with inter-nibble carry and carry-out: A=8'hF9, B=8'hC6, mode=0 → q=9'h1BF. Also A=8'h0D, B=8'h8D → q=9'h09A, which exercises the low-nibble carry.
- Subtract, no borrow / borrow:
  - A=8'h76, B=8'h3D, mode=1 → q=9'h139.
  - A=8'h12, B=8'h8F, mode=1 → q=9'h083.
- Busy rejection: start at edge N, then change A/B/mode and pulse start at N+1 and N+2 → a single done, with the result from the operands of N only; the next start is accepted at N+4.
- Reset mid-op: assert rst asynchronously while in HIGH → all outputs 0 immediately; no done pulse; a fresh op after rst falls (A=8'hE5, B=8'h77, mode=0) → q=9'h15C.
- Back-to-back with start held high for 12 cycles using 8'h65+8'h12, 8'h01+8'h0D, 8'hC5+8'hAA → three done pulses 4 cycles apart with q=9'h077, 9'h00E, 9'h16F.
